// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin front end for a shared combinational 4-bit ALU.
// Optional grant counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter_seq #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [7:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic [3:0] alu_sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_res,
   input  logic       alu_cout,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_res,
   output logic       rsp_cout,
   output logic       busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0] gnt_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RESP
   } state_t;

   localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

   state_t     state;
   logic       lastGnt;
   logic [3:0] settleCnt;
   logic [1:0] grant;
   logic       gntId;
   logic       accept;
   logic [3:0] selOp;
   logic [3:0] selA;
   logic [3:0] selB;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 2'b00;
      if (state == IDLE && !rst) begin
         grant[0] = req_valid[0] & (~req_valid[1] | lastGnt);
         grant[1] = req_valid[1] & (~req_valid[0] | ~lastGnt);
      end
   end

   assign req_ready = grant;
   assign accept    = |grant;
   assign gntId     = grant[1];
   assign selOp     = gntId ? req_op[7:4] : req_op[3:0];
   assign selA      = gntId ? req_a[7:4]  : req_a[3:0];
   assign selB      = gntId ? req_b[7:4]  : req_b[3:0];

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lastGnt   <= 1'b1;
         settleCnt <= 4'd0;
         alu_sel   <= 4'd0;
         alu_a     <= 4'd0;
         alu_b     <= 4'd0;
         rsp_id    <= 1'b0;
         rsp_res   <= 4'd0;
         rsp_cout  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  alu_sel   <= selOp;
                  alu_a     <= selA;
                  alu_b     <= selB;
                  rsp_id    <= gntId;
                  lastGnt   <= gntId;
                  settleCnt <= SettleInit;
                  state     <= SETTLE;
               end
            end
            SETTLE: begin
               // Capture on the last settle cycle so the ALU saw stable operands.
               if (settleCnt <= 4'd1) begin
                  rsp_res   <= alu_res;
                  rsp_cout  <= alu_cout;
                  settleCnt <= 4'd0;
                  state     <= RESP;
               end else begin
                  settleCnt <= settleCnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [7:0] gntCnt0;
   logic [7:0] gntCnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gntCnt0 <= 8'd0;
         gntCnt1 <= 8'd0;
      end else begin
         if (grant[0] && gntCnt0 != 8'hFF) begin
            gntCnt0 <= gntCnt0 + 8'd1;
         end
         if (grant[1] && gntCnt1 != 8'hFF) begin
            gntCnt1 <= gntCnt1 + 8'd1;
         end
      end
   end

   assign gnt_cnt = {gntCnt1, gntCnt0};
`endif

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Randomised self-checking bench for alu_arbiter_seq against a transaction model.
// Covers gnt_cnt as well when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter_seq;

   localparam int S = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [3:0] alu_sel;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_res;
   logic       alu_cout;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [3:0] rsp_res;
   logic       rsp_cout;
   logic       busy;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] gnt_cnt;
`endif

   logic [4:0] aluSum;
   assign aluSum   = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_res  = aluSum[3:0];
   assign alu_cout = aluSum[4];

   always #5 clk = ~clk;

   alu_arbiter_seq #(.SETTLE_CYCLES(S)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op(req_op),
      .req_a(req_a),
      .req_b(req_b),
      .alu_sel(alu_sel),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_res(alu_res),
      .alu_cout(alu_cout),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id(rsp_id),
      .rsp_res(rsp_res),
      .rsp_cout(rsp_cout),
      .busy(busy)
`ifdef ALU_ARB_STATS_EN
      ,
      .gnt_cnt(gnt_cnt)
`endif
   );

   int tests = 0;
   int fails = 0;
   bit lastG = 1'b1;

   task automatic do_reset();
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lastG = 1'b1;
   endtask

   // One transaction: model picks winner and expected sum, then checks timing.
   task automatic run_op(input logic [1:0] v, input logic [7:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input int stall, input bit keep);
      int w;
      logic [3:0] eOp, eA, eB;
      logic [4:0] eSum;
      logic [1:0] eRdy, saved;
      @(negedge clk);
      req_valid = v;
      req_op = op;
      req_a = a;
      req_b = b;
      rsp_ready = (stall == 0);
      #1;
      if (v == 2'b11) w = lastG ? 0 : 1;
      else w = v[1] ? 1 : 0;
      eOp  = (w == 1) ? op[7:4] : op[3:0];
      eA   = (w == 1) ? a[7:4] : a[3:0];
      eB   = (w == 1) ? b[7:4] : b[3:0];
      eSum = {1'b0, eA} + {1'b0, eB};
      eRdy = (w == 1) ? 2'b10 : 2'b01;
      tests++;
      if (req_ready !== eRdy) begin
         fails++;
         $display("FAIL grant: req_ready=%b expected %b", req_ready, eRdy);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_busy: busy=%b expected 0", busy);
      end
      @(posedge clk);
      #1;
      if (!keep) req_valid = 2'b00;
      lastG = (w == 1);
      tests++;
      if ({alu_sel, alu_a, alu_b} !== {eOp, eA, eB}) begin
         fails++;
         $display("FAIL issue: sel/a/b=%h/%h/%h expected %h/%h/%h",
                  alu_sel, alu_a, alu_b, eOp, eA, eB);
      end
      for (int j = 0; j < S; j++) begin
         tests++;
         if ({rsp_valid, req_ready, busy} !== 4'b0001) begin
            fails++;
            $display("FAIL settle: valid/ready/busy=%b/%b/%b expected 0/00/1",
                     rsp_valid, req_ready, busy);
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if ({rsp_valid, rsp_id, rsp_cout, rsp_res} !== {1'b1, (w == 1), eSum}) begin
         fails++;
         $display("FAIL resp: valid/id/cout/res=%b/%b/%b/%h expected 1/%0d/%b/%h",
                  rsp_valid, rsp_id, rsp_cout, rsp_res, w, eSum[4], eSum[3:0]);
      end
      saved = req_valid;
      for (int k = 0; k < stall; k++) begin
         req_valid = 2'b11;
         @(posedge clk);
         #1;
         tests++;
         if ({rsp_valid, rsp_id, rsp_cout, rsp_res, req_ready, busy} !==
             {1'b1, (w == 1), eSum, 2'b00, 1'b1}) begin
            fails++;
            $display("FAIL stall: valid/id/cout/res/ready/busy=%b/%b/%b/%h/%b/%b",
                     rsp_valid, rsp_id, rsp_cout, rsp_res, req_ready, busy);
         end
      end
      req_valid = saved;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      tests++;
      if ({rsp_valid, busy, alu_a, alu_b} !== {2'b00, eA, eB}) begin
         fails++;
         $display("FAIL release: valid/busy/a/b=%b/%b/%h/%h expected 0/0/%h/%h",
                  rsp_valid, busy, alu_a, alu_b, eA, eB);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      req_op = 8'hFF;
      req_a = 8'hFF;
      req_b = 8'hFF;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_cout, busy} !== 10'd0) begin
         fails++;
         $display("FAIL reset_ctl: ready/valid/id/res/cout/busy=%b/%b/%b/%h/%b/%b",
                  req_ready, rsp_valid, rsp_id, rsp_res, rsp_cout, busy);
      end
      tests++;
      if ({alu_sel, alu_a, alu_b} !== 12'd0) begin
         fails++;
         $display("FAIL reset_alu: sel/a/b=%h/%h/%h expected 0/0/0",
                  alu_sel, alu_a, alu_b);
      end
`ifdef ALU_ARB_STATS_EN
      tests++;
      if (gnt_cnt !== 16'd0) begin
         fails++;
         $display("FAIL reset_cnt: gnt_cnt=%h expected 0000", gnt_cnt);
      end
`endif
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      rst = 1'b0;
      lastG = 1'b1;
   endtask

   task automatic test_basic();
      run_op(2'b01, 8'hA0, 8'hC5, 8'h73, 0, 0);
      run_op(2'b10, 8'h3B, 8'h92, 8'h91, 0, 0);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_op(2'b11, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1);
         tests++;
         if (rsp_id !== i[0]) begin
            fails++;
            $display("FAIL rr_seq: rsp_id=%b expected %b", rsp_id, i[0]);
         end
      end
      req_valid = 2'b00;
   endtask

   task automatic test_stall();
      run_op(2'b10, 8'h5A, 8'h7E, 8'hC3, 10, 0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 2'b10;
      req_op = 8'h41;
      req_a = 8'h62;
      req_b = 8'h73;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      rst = 1'b1;
      #1;
      tests++;
      if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_cout, busy,
           alu_sel, alu_a, alu_b} !== 22'd0) begin
         fails++;
         $display("FAIL mid_reset: ready/valid/busy/sel/a/b=%b/%b/%b/%h/%h/%h",
                  req_ready, rsp_valid, busy, alu_sel, alu_a, alu_b);
      end
      @(negedge clk);
      rst = 1'b0;
      lastG = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({rsp_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL mid_quiet: valid/busy=%b/%b expected 0/0",
                     rsp_valid, busy);
         end
      end
      run_op(2'b11, 8'h12, 8'h34, 8'h56, 0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end
      req_valid = 2'b00;
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         run_op(2'b01, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
      end
      tests++;
      if (gnt_cnt !== 16'h00FF) begin
         fails++;
         $display("FAIL gnt_sat: gnt_cnt=%h expected 00ff", gnt_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_stall();
      test_reset_mid();
      test_random();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_arbiter_seq.md
ALU_ARBITER_SEQ -- requirements
Module: alu_arbiter_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, cycles (1..15) ALU operands are held before result capture.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  2  per-requester command valid, bit i = requester i.
REQ-005 SHALL have port req_ready  out  2  per-requester command accept, one-hot or zero.
REQ-006 SHALL have port req_op  in  8  ALU select codes, [3:0] requester 0, [7:4] requester 1.
REQ-007 SHALL have port req_a  in  8  operand a, same packing.
REQ-008 SHALL have port req_b  in  8  operand b, same packing.
REQ-009 SHALL have port alu_sel  out  4  function select to ALU, {A,B,C,D} with A = bit 3.
REQ-010 SHALL have port alu_a  out  4  operand a to ALU.
REQ-011 SHALL have port alu_b  out  4  operand b to ALU.
REQ-012 SHALL have port alu_res  in  4  ALU result.
REQ-013 SHALL have port alu_cout  in  1  ALU carry out.
REQ-014 SHALL have port rsp_valid  out  1  response valid.
REQ-015 SHALL have port rsp_ready  in  1  response accept.
REQ-016 SHALL have port rsp_id  out  1  index of requester owning response.
REQ-017 SHALL have port rsp_res  out  4  captured result.
REQ-018 SHALL have port rsp_cout  out  1  captured carry.
REQ-019 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> SETTLE -> RESP -> IDLE, one transaction in flight.
REQ-021 In IDLE, SHALL drive req_ready one-hot to the arbitration winner among asserted req_valid bits; zero in all other states.
REQ-022 Arbitration SHALL be round-robin: on simultaneous valid, winner is the requester not granted last; single valid wins unconditionally.
REQ-023 On handshake (req_valid[i] & req_ready[i]) at cycle T: SHALL register op/a/b of requester i into alu_sel/alu_a/alu_b (visible T+1), record rsp_id = i, update last-grant, load settle counter with SETTLE_CYCLES, enter SETTLE.
REQ-024 SETTLE SHALL decrement the counter each cycle; at end of cycle T+SETTLE_CYCLES SHALL capture alu_res/alu_cout into rsp_res/rsp_cout and enter RESP.
REQ-025 rsp_valid SHALL be high exactly while in RESP (first at T+SETTLE_CYCLES+1); rsp_id/rsp_res/rsp_cout SHALL stay stable while rsp_valid high.
REQ-026 On rsp_valid & rsp_ready SHALL return to IDLE; next handshake earliest one cycle later (throughput one op per SETTLE_CYCLES+2 cycles min).
REQ-027 rsp_ready low SHALL stall indefinitely in RESP with no new accepts.
REQ-028 alu_sel/alu_a/alu_b SHALL hold the last issued values until the next handshake.
REQ-029 Requester inputs not granted SHALL be ignored; a requester may drop req_valid before grant without side effect.

Reset
REQ-030 While rst high: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_res 0, rsp_cout 0, alu_sel/alu_a/alu_b 0, counter 0, busy 0, last-grant = requester 1 (so requester 0 wins first tie).
REQ-031 Reset mid-transaction SHALL discard it with no response emitted after release.

Configuration
REQ-032 With macro ALU_ARB_STATS_EN defined, SHALL add output gnt_cnt (16 bits: [7:0] requester 0, [15:8] requester 1), each incremented per handshake, saturating at 255, reset to 0; without it, the port and counters SHALL be absent and all other behaviour identical.

Verification (bench ALU model: alu_res = a+b[3:0], alu_cout = carry)
REQ-033 req_valid=01, op=4'h0, a=5, b=3, rsp_ready=1, SETTLE_CYCLES=1 -> req_ready=01 at T, rsp_valid at T+2 with rsp_id=0, rsp_res=8, rsp_cout=0.
REQ-034 a=9, b=9 from requester 1 -> rsp_id=1, rsp_res=2, rsp_cout=1.
REQ-035 req_valid=11 held continuously after reset -> grants alternate 0,1,0,1; rsp_id sequence matches.
REQ-036 rsp_ready held low 10 cycles -> rsp_valid and data stable, req_ready stays 00, busy=1; accept on release, back to IDLE next cycle.
REQ-037 rst pulsed during SETTLE -> all outputs at reset values, no rsp_valid afterwards until a new request.
REQ-038 With ALU_ARB_STATS_EN, 300 handshakes from requester 0 -> gnt_cnt[7:0]=255, gnt_cnt[15:8]=0.
